wb_master_arbiter: RTL and testbench

//  Shares one wb_master_interface command port between NUM_REQ requesters.

---
 rtl/wb_master_arbiter.sv | 157 +++++++++++++++
 tb/tb_wb_master_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_arbiter.sv
// Arbitrates NUM_REQ requesters onto one wb_master_interface command port.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin selection; otherwise fixed priority (lowest index wins).
module wb_master_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned dw      = 32,
    parameter int unsigned aw      = 32,
    parameter int unsigned IW      = $clog2(NUM_REQ)
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*aw-1:0] req_address,
    input  logic [NUM_REQ*4-1:0]  req_sel,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*dw-1:0] req_data_wr,
    output logic [NUM_REQ-1:0]    req_done,
    output logic [dw-1:0]         req_data_rd,
    output logic [IW-1:0]         grant_idx,
    output logic                  busy,
    output logic                  m_start,
    output logic [aw-1:0]         m_address,
    output logic [3:0]            m_selection,
    output logic                  m_write,
    output logic [dw-1:0]         m_data_wr,
    input  logic [dw-1:0]         m_data_rd,
    input  logic                  m_active
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

    state_t               state, state_d;
    logic                 start_d, write_d, busy_d;
    logic [aw-1:0]        address_d;
    logic [3:0]           sel_d;
    logic [dw-1:0]        data_wr_d, data_rd_d;
    logic [NUM_REQ-1:0]   done_d;
    logic [IW-1:0]        grant_d, winner_c;
    logic                 grant_c;

    logic [aw-1:0]        addr_arr [NUM_REQ];
    logic [3:0]           sel_arr  [NUM_REQ];
    logic [dw-1:0]        data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_address[g*aw +: aw];
        assign sel_arr[g]  = req_sel[g*4 +: 4];
        assign data_arr[g] = req_data_wr[g*dw +: dw];
    end

    assign grant_c = (state == IDLE) && (|req) && !m_active;

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic [IW-1:0] last_grant;
    logic          found_c;

    // Search begins just after the previous winner and wraps around.
    always_comb begin
        winner_c = '0;
        found_c  = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!found_c && req[IW'((32'(last_grant) + k) % NUM_REQ)]) begin
                found_c  = 1'b1;
                winner_c = IW'((32'(last_grant) + k) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n)
            last_grant <= IW'(NUM_REQ - 1);
        else if (grant_c)
            last_grant <= winner_c;
    end
`else
    // Descending scan so the lowest set index is the final assignment.
    always_comb begin
        winner_c = '0;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            if (req[IW'(k - 1)])
                winner_c = IW'(k - 1);
        end
    end
`endif

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state       <= IDLE;
            m_start     <= 1'b0;
            m_address   <= '0;
            m_selection <= '0;
            m_write     <= 1'b0;
            m_data_wr   <= '0;
            req_done    <= '0;
            req_data_rd <= '0;
            grant_idx   <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            m_start     <= start_d;
            m_address   <= address_d;
            m_selection <= sel_d;
            m_write     <= write_d;
            m_data_wr   <= data_wr_d;
            req_done    <= done_d;
            req_data_rd <= data_rd_d;
            grant_idx   <= grant_d;
            busy        <= busy_d;
        end
    end

    always_comb begin
        state_d   = state;
        start_d   = 1'b0;
        address_d = m_address;
        sel_d     = m_selection;
        write_d   = m_write;
        data_wr_d = m_data_wr;
        done_d    = '0;
        data_rd_d = req_data_rd;
        grant_d   = grant_idx;

        case (state)
            IDLE: begin
                if (grant_c) begin
                    address_d = addr_arr[winner_c];
                    sel_d     = sel_arr[winner_c];
                    write_d   = req_write[winner_c];
                    data_wr_d = data_arr[winner_c];
                    grant_d   = winner_c;
                    start_d   = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: state_d = BUSY;
            BUSY: begin
                // Master dropping active marks the end of the bus cycle, including err/rty.
                if (!m_active) begin
                    if (!m_write)
                        data_rd_d = m_data_rd;
                    done_d  = NUM_REQ'(1) << grant_idx;
                    state_d = DONE;
                end
            end
            DONE: begin
                address_d = '0;
                sel_d     = '0;
                write_d   = 1'b0;
                data_wr_d = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Randomized bench for wb_master_arbiter with a transaction-level arbitration model and a behavioural master.
module tb_wb_master_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int IW      = 2;

    logic                  wb_clk = 1'b0;
    logic                  wb_rst_n;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*AW-1:0] req_address;
    logic [NUM_REQ*4-1:0]  req_sel;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*DW-1:0] req_data_wr;
    logic [NUM_REQ-1:0]    req_done;
    logic [DW-1:0]         req_data_rd;
    logic [IW-1:0]         grant_idx;
    logic                  busy;
    logic                  m_start;
    logic [AW-1:0]         m_address;
    logic [3:0]            m_selection;
    logic                  m_write;
    logic [DW-1:0]         m_data_wr;
    logic [DW-1:0]         m_data_rd;
    logic                  m_active;

    always #5 wb_clk = ~wb_clk;

    logic          req_a  [NUM_REQ];
    logic [AW-1:0] addr_a [NUM_REQ];
    logic [3:0]    sel_a  [NUM_REQ];
    logic          wr_a   [NUM_REQ];
    logic [DW-1:0] dat_a  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
        assign req[g]                 = req_a[g];
        assign req_address[g*AW +: AW] = addr_a[g];
        assign req_sel[g*4 +: 4]      = sel_a[g];
        assign req_write[g]           = wr_a[g];
        assign req_data_wr[g*DW +: DW] = dat_a[g];
    end

    wb_master_arbiter #(
        .NUM_REQ(NUM_REQ), .dw(DW), .aw(AW), .IW(IW)
    ) dut (
        .wb_clk      (wb_clk),
        .wb_rst_n    (wb_rst_n),
        .req         (req),
        .req_address (req_address),
        .req_sel     (req_sel),
        .req_write   (req_write),
        .req_data_wr (req_data_wr),
        .req_done    (req_done),
        .req_data_rd (req_data_rd),
        .grant_idx   (grant_idx),
        .busy        (busy),
        .m_start     (m_start),
        .m_address   (m_address),
        .m_selection (m_selection),
        .m_write     (m_write),
        .m_data_wr   (m_data_wr),
        .m_data_rd   (m_data_rd),
        .m_active    (m_active)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural master and reference-model state
    logic          start_q, wr_q, rst_q, hold_active, cur_err;
    int            cnt, cur_wait;
    logic [DW-1:0] cur_rdata;
    int            rr_last;
    logic [DW-1:0] exp_rd;

    task automatic step();
        start_q = m_start;
        wr_q    = m_write;
        rst_q   = !wb_rst_n;
        @(posedge wb_clk);
        #1;
        if (rst_q) begin
            m_active = 1'b0;
            cnt      = 0;
        end else if (hold_active) begin
            m_active = 1'b1;
            cnt      = 0;
        end else if (start_q) begin
            m_active  = 1'b1;
            cnt       = cur_wait;
            m_data_rd = $urandom;
        end else if (m_active) begin
            if (cnt == 0) begin
                m_active = 1'b0;
                if (wr_q)         m_data_rd = $urandom;
                else if (cur_err) m_data_rd = '0;
                else              m_data_rd = cur_rdata;
            end else begin
                cnt--;
            end
        end
    endtask

    function automatic int pick();
        int w;
        int i;
        w = -1;
`ifdef WB_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= NUM_REQ; k++) begin
            i = (rr_last + k) % NUM_REQ;
            if (w < 0 && req_a[IW'(i)]) w = i;
        end
`else
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            i = k;
            if (req_a[IW'(i)]) w = i;
        end
`endif
        return w;
    endfunction

    function automatic logic any_req();
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) r = r | req_a[IW'(i)];
        return r;
    endfunction

    task automatic rand_fields(input int i);
        addr_a[IW'(i)] = $urandom;
        sel_a[IW'(i)]  = 4'($urandom_range(15, 0));
        wr_a[IW'(i)]   = 1'($urandom_range(1, 0));
        dat_a[IW'(i)]  = $urandom;
    endtask

    // Starts in an IDLE cycle with a request pending; ends in the IDLE cycle after DONE.
    task automatic txn(input int wait_n, input logic err, input logic [DW-1:0] rdata,
                       input logic [NUM_REQ-1:0] keep_mask, output int got);
        int            w, n;
        logic [AW-1:0] ea;
        logic [3:0]    es;
        logic          ew;
        logic [DW-1:0] ed;
        logic          keep;
        got = -1;
        w   = pick();
        if (w < 0) return;
        ea   = addr_a[IW'(w)];
        es   = sel_a[IW'(w)];
        ew   = wr_a[IW'(w)];
        ed   = dat_a[IW'(w)];
        keep = keep_mask[IW'(w)];
        cur_wait  = wait_n;
        cur_err   = err;
        cur_rdata = rdata;

        step();
        check_eq("issue_start", 64'(m_start), 64'(1));
        check_eq("issue_addr",  64'(m_address), 64'(ea));
        check_eq("issue_sel",   64'(m_selection), 64'(es));
        check_eq("issue_write", 64'(m_write), 64'(ew));
        check_eq("issue_wdata", 64'(m_data_wr), 64'(ed));
        check_eq("issue_grant", 64'(grant_idx), 64'(w));
        check_eq("issue_busy",  64'(busy), 64'(1));
        check_eq("issue_nodone", 64'(req_done), 64'(0));
        got     = int'(grant_idx);
        rr_last = w;
        // Fields change after the grant; the transfer in flight must not follow them.
        rand_fields(w);
        if (!keep && $urandom_range(1, 0) == 1) req_a[IW'(w)] = 1'b0;

        step();
        n = 2;
        check_eq("busy_start_low", 64'(m_start), 64'(0));
        check_eq("busy_addr_hold", 64'(m_address), 64'(ea));
        while (req_done == '0 && n < 12 + wait_n) begin
            step();
            n++;
            if (req_done == '0) check_eq("busy_start_low", 64'(m_start), 64'(0));
        end
        check_eq("done_latency", 64'(n), 64'(4 + wait_n));
        check_eq("done_onehot", 64'(req_done), 64'(1) << w);
        if (!ew) exp_rd = err ? '0 : rdata;
        check_eq("done_rdata", 64'(req_data_rd), 64'(exp_rd));
        check_eq("done_grant", 64'(grant_idx), 64'(w));
        check_eq("done_busy",  64'(busy), 64'(1));
        req_a[IW'(w)] = keep;

        step();
        check_eq("idle_done_clr", 64'(req_done), 64'(0));
        check_eq("idle_busy",     64'(busy), 64'(0));
        check_eq("idle_start",    64'(m_start), 64'(0));
        check_eq("idle_addr",     64'(m_address), 64'(0));
        check_eq("idle_sel",      64'(m_selection), 64'(0));
        check_eq("idle_write",    64'(m_write), 64'(0));
        check_eq("idle_wdata",    64'(m_data_wr), 64'(0));
    endtask

    int got;
    int order_a [4] = '{0, 1, 2, 3};
`ifdef WB_ARB_ROUND_ROBIN_EN
    int order_b [5] = '{0, 1, 2, 3, 0};
`else
    int order_b [5] = '{0, 0, 0, 0, 0};
`endif

    initial begin
        wb_rst_n    = 1'b0;
        hold_active = 1'b0;
        m_active    = 1'b0;
        m_data_rd   = '0;
        start_q     = 1'b0;
        wr_q        = 1'b0;
        rst_q       = 1'b1;
        cnt         = 0;
        cur_wait    = 0;
        cur_err     = 1'b0;
        cur_rdata   = '0;
        rr_last     = NUM_REQ - 1;
        exp_rd      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[IW'(i)] = 1'b0;
            addr_a[IW'(i)] = '0;
            sel_a[IW'(i)]  = '0;
            wr_a[IW'(i)]   = 1'b0;
            dat_a[IW'(i)]  = '0;
        end

        repeat (3) step();
        check_eq("rst_busy",  64'(busy), 64'(0));
        check_eq("rst_start", 64'(m_start), 64'(0));
        check_eq("rst_addr",  64'(m_address), 64'(0));
        check_eq("rst_done",  64'(req_done), 64'(0));
        check_eq("rst_rdata", 64'(req_data_rd), 64'(0));
        check_eq("rst_grant", 64'(grant_idx), 64'(0));
        wb_rst_n = 1'b1;
        step();

        // Single read
        req_a[1] = 1'b1; addr_a[1] = 32'h100; sel_a[1] = 4'hF; wr_a[1] = 1'b0; dat_a[1] = $urandom;
        txn(0, 1'b0, 32'hDEADBEEF, '0, got);
        check_eq("t1_grant", 64'(got), 64'(1));
        check_eq("t1_rdata", 64'(req_data_rd), 64'(32'hDEADBEEF));

        // Single write leaves read data alone
        req_a[2] = 1'b1; addr_a[2] = 32'h20; sel_a[2] = 4'hF; wr_a[2] = 1'b1; dat_a[2] = 32'hA5A5_0001;
        txn(0, 1'b0, $urandom, '0, got);
        check_eq("t2_grant", 64'(got), 64'(2));
        check_eq("t2_rdata_hold", 64'(req_data_rd), 64'(32'hDEADBEEF));

        // Five wait states
        req_a[1] = 1'b1; addr_a[1] = $urandom; sel_a[1] = 4'h3; wr_a[1] = 1'b0;
        txn(5, 1'b0, 32'h1234_5678, '0, got);

        // Error on a read returns zero data
        req_a[3] = 1'b1; addr_a[3] = $urandom; wr_a[3] = 1'b0;
        txn(0, 1'b1, 32'hFFFF_FFFF, '0, got);
        check_eq("t5_err_rdata", 64'(req_data_rd), 64'(0));

        // Master still active in IDLE holds off the grant
        hold_active = 1'b1;
        step();
        req_a[2] = 1'b1;
        rand_fields(2);
        repeat (3) begin
            step();
            check_eq("hold_no_start", 64'(m_start), 64'(0));
            check_eq("hold_not_busy", 64'(busy), 64'(0));
        end
        hold_active = 1'b0;
        step();
        txn(1, 1'b0, $urandom, '0, got);
        check_eq("hold_grant", 64'(got), 64'(2));

        // Reset in the middle of BUSY
        req_a[3] = 1'b1; rand_fields(3); wr_a[3] = 1'b0;
        cur_wait = 6; cur_err = 1'b0; cur_rdata = $urandom;
        step();
        check_eq("rb_start", 64'(m_start), 64'(1));
        step();
        step();
        check_eq("rb_busy", 64'(busy), 64'(1));
        wb_rst_n = 1'b0;
        req_a[3] = 1'b0;
        step();
        check_eq("rb_busy_clr",  64'(busy), 64'(0));
        check_eq("rb_start_clr", 64'(m_start), 64'(0));
        check_eq("rb_addr_clr",  64'(m_address), 64'(0));
        check_eq("rb_sel_clr",   64'(m_selection), 64'(0));
        check_eq("rb_write_clr", 64'(m_write), 64'(0));
        check_eq("rb_wdata_clr", 64'(m_data_wr), 64'(0));
        check_eq("rb_done_clr",  64'(req_done), 64'(0));
        check_eq("rb_grant_clr", 64'(grant_idx), 64'(0));
        check_eq("rb_rdata_clr", 64'(req_data_rd), 64'(0));
        wb_rst_n = 1'b1;
        rr_last  = NUM_REQ - 1;
        exp_rd   = '0;
        repeat (8) begin
            step();
            check_eq("rb_no_done", 64'(req_done), 64'(0));
        end

        // All four request, each drops on its own done
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[IW'(i)] = 1'b1;
            rand_fields(i);
        end
        for (int j = 0; j < 4; j++) begin
            txn($urandom_range(2, 0), 1'b0, $urandom, '0, got);
            check_eq("t3_order", 64'(got), 64'(order_a[j]));
        end

        // Requester 0 keeps requesting
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[IW'(i)] = 1'b1;
            rand_fields(i);
        end
        for (int j = 0; j < 5; j++) begin
            txn(0, 1'b0, $urandom, 4'b0001, got);
            check_eq("t3_keep_order", 64'(got), 64'(order_b[j]));
        end
        req_a[0] = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) req_a[IW'(i)] = 1'b0;
        step();

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            logic [NUM_REQ-1:0] m;
            if (!any_req()) begin
                repeat ($urandom_range(3, 0)) begin
                    step();
                    check_eq("rnd_idle_busy", 64'(busy), 64'(0));
                end
                m = NUM_REQ'($urandom_range(15, 1));
            end else begin
                m = ($urandom_range(3, 0) == 0) ? NUM_REQ'($urandom_range(15, 0)) : '0;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (m[IW'(i)] && !req_a[IW'(i)]) begin
                    req_a[IW'(i)] = 1'b1;
                    rand_fields(i);
                end
            end
            txn($urandom_range(6, 0), ($urandom_range(7, 0) == 0), $urandom,
                ($urandom_range(4, 0) == 0) ? NUM_REQ'($urandom_range(15, 0)) : '0, got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
